ws_systolic_array: RTL and testbench
====================================

WS_SYSTOLIC_ARRAY -- requirements
Module: ws_systolic_array

Interface
REQ-001 Parameter BIT_WIDTH, default 8: width of each activation and weight element.
REQ-002 Parameter ACC_WIDTH, default 16: width of each accumulator and result lane.
REQ-003 Parameter SIZE, default 4: array dimension; SIZE x SIZE PEs, SIZE lanes per vector.
REQ-004 Parameter SIGNED, default 0: 0 selects unsigned arithmetic, 1 selects two's-complement.
REQ-005 clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high; clears all state.
REQ-007 wt_valid  in  1  weight row offered this cycle.
REQ-008 wt_row  in  BIT_WIDTH*SIZE  weight row; lane j at bits [j*BIT_WIDTH +: BIT_WIDTH].
REQ-009 wt_ready  out  1  block accepts a weight row this cycle.
REQ-010 wt_reload  in  1  single-cycle request to replace the stationary weights.
REQ-011 in_valid  in  1  activation vector offered this cycle.
REQ-012 in_vec  in  BIT_WIDTH*SIZE  unskewed activation vector; lane k feeds array row k.
REQ-013 in_ready  out  1  block accepts an activation vector this cycle.
REQ-014 out_valid  out  1  out_vec holds a result this cycle; no output backpressure.
REQ-015 out_vec  out  ACC_WIDTH*SIZE  de-skewed result vector; lane j at bits [j*ACC_WIDTH +: ACC_WIDTH].
REQ-016 busy  out  1  one or more accepted vectors still in flight.

Function
REQ-017 The FSM SHALL have three states: LOAD (wt_ready=1, in_ready=0), COMPUTE (wt_ready=0, in_ready=1), DRAIN (both 0).
REQ-018 A weight beat SHALL transfer when wt_valid&&wt_ready; beat r (0..SIZE-1) loads array row r; the row counter wraps to 0 after beat SIZE-1.
REQ-019 On the beat-(SIZE-1) transfer, the FSM SHALL go LOAD->COMPUTE, and in_ready SHALL be 1 the next cycle.
REQ-020 A vector SHALL transfer when in_valid&&in_ready; result lane j = sum over k of in_vec[k]*W[k][j].
REQ-021 Products SHALL be zero- or sign-extended (per SIGNED) to ACC_WIDTH; sums SHALL wrap modulo 2^ACC_WIDTH with no saturation and no overflow flag.
REQ-022 Input skew (row k delayed k cycles) and output de-skew SHALL be internal; result latency SHALL be exactly 2*SIZE cycles from the accept edge to out_valid.
REQ-023 Throughput SHALL be one vector per cycle; idle cycles SHALL propagate as bubbles; result order SHALL equal accept order.
REQ-024 wt_reload in COMPUTE SHALL move the FSM to DRAIN; a vector accepted in the same cycle SHALL still complete.
REQ-025 DRAIN->LOAD SHALL occur on the cycle after the last in-flight result's out_valid, or immediately when busy=0.
REQ-026 wt_reload in LOAD or DRAIN, and wt_valid outside LOAD, SHALL be ignored.
REQ-027 busy SHALL be 1 from the cycle after an accept until the cycle after the last pending out_valid.
REQ-028 out_vec SHALL be 0 whenever out_valid=0.

Reset
REQ-029 On reset assertion, regardless of clk: state=LOAD, row counter=0, all weights, accumulators and pipeline valids=0, out_valid=0, out_vec=0, busy=0.
REQ-030 Reset mid-COMPUTE or mid-DRAIN SHALL discard every in-flight vector; no out_valid is produced for them after reset.
REQ-031 The first weight beat SHALL be accepted on the first rising edge after reset deasserts.

Verification (SIZE=4, BIT_WIDTH=8, ACC_WIDTH=16)
REQ-032 Identity weights, in_vec lanes 0..3 = (1,2,3,4) -> out_vec lanes (1,2,3,4), out_valid exactly 8 cycles after the accept.
REQ-033 All-ones weights, 8 back-to-back vectors with lanes (n,n,n,n) for n=1..8 -> 8 consecutive out_valid cycles, each lane 4n, in order.
REQ-034 SIGNED=0, all elements 0xFF -> every lane 0xF804 (260100 mod 65536); SIGNED=1, x=0xFF (-1), W=0x02 -> every lane 0xFFF8.
REQ-035 wt_reload with 3 vectors in flight -> in_ready=0 next cycle, all 3 results emerge, wt_ready=1 the cycle after the third out_valid, busy=0 then.
REQ-036 reset pulse 2 cycles after an accept -> out_valid stays 0, state LOAD, then a reload with 2*identity gives (2,4,6,8) for input (1,2,3,4).

Source files
------------

// File: rtl/ws_systolic_array.sv
// Weight-stationary SIZE x SIZE multiply-accumulate array. Activations flow
// left-to-right, partial sums flow top-to-bottom; skew/de-skew are internal.
module ws_systolic_array #(
  parameter int BIT_WIDTH = 8,
  parameter int ACC_WIDTH = 16,
  parameter int SIZE      = 4,
  parameter int SIGNED    = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wt_valid,
  input  logic [BIT_WIDTH*SIZE-1:0] wt_row,
  output logic                      wt_ready,
  input  logic                      wt_reload,
  input  logic                      in_valid,
  input  logic [BIT_WIDTH*SIZE-1:0] in_vec,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [ACC_WIDTH*SIZE-1:0] out_vec,
  output logic                      busy
);

  localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int EXT_W = ACC_WIDTH - BIT_WIDTH;
  localparam int LAT   = 2 * SIZE;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                      state_reg;
  logic                        wt_ready_reg;
  logic                        in_ready_reg;
  logic [ROW_W-1:0]            row_cnt_reg;
  logic [LAT-1:0]              vpipe_reg;
  logic                        out_valid_reg;
  logic [ACC_WIDTH*SIZE-1:0]   out_vec_reg;

  logic                        wt_accept;
  logic                        in_accept;
  logic                        row_last;

  logic [BIT_WIDTH*SIZE-1:0]   w_rows   [SIZE];
  logic [BIT_WIDTH-1:0]        act_left [SIZE];
  logic [BIT_WIDTH-1:0]        act_w    [SIZE][SIZE];
  logic [ACC_WIDTH-1:0]        psum_w   [SIZE][SIZE];
  logic [ACC_WIDTH*SIZE-1:0]   aligned;

  assign wt_accept = wt_valid && wt_ready_reg;
  assign in_accept = in_valid && in_ready_reg;
  assign row_last  = (row_cnt_reg == ROW_W'(SIZE - 1));

  // Control FSM; ready flags are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= LOAD;
      wt_ready_reg <= 1'b1;
      in_ready_reg <= 1'b0;
      row_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (wt_valid) begin
            if (row_last) begin
              row_cnt_reg  <= '0;
              state_reg    <= COMPUTE;
              wt_ready_reg <= 1'b0;
              in_ready_reg <= 1'b1;
            end else begin
              row_cnt_reg <= row_cnt_reg + 1'b1;
            end
          end
        end
        COMPUTE: begin
          if (wt_reload) begin
            state_reg    <= DRAIN;
            in_ready_reg <= 1'b0;
          end
        end
        DRAIN: begin
          // Once nothing remains in the pipe, the final result (if any) is
          // sitting in the output register, so LOAD begins the cycle after.
          if (vpipe_reg == '0) begin
            state_reg    <= LOAD;
            wt_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= LOAD;
          wt_ready_reg <= 1'b1;
          in_ready_reg <= 1'b0;
        end
      endcase
    end
  end

  // Stationary weight rows, one register per array row.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_wrow
    logic [BIT_WIDTH*SIZE-1:0] w_row_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        w_row_reg <= '0;
      end else if (wt_accept && (row_cnt_reg == ROW_W'(gi))) begin
        w_row_reg <= wt_row;
      end
    end
    assign w_rows[gi] = w_row_reg;
  end

  // Input skew: row k enters column 0 k cycles after row 0; bubbles are zeros.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_skew
    localparam int D = gi + 1;
    logic [BIT_WIDTH-1:0] sk_reg [D];
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        for (int d = 0; d < D; d++) sk_reg[d] <= '0;
      end else begin
        sk_reg[0] <= in_accept ? in_vec[gi*BIT_WIDTH +: BIT_WIDTH] : '0;
        for (int d = 1; d < D; d++) sk_reg[d] <= sk_reg[d-1];
      end
    end
    assign act_left[gi] = sk_reg[D-1];
  end

  // Processing elements: gi is the array row (activation lane), gj the column.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_row
    for (genvar gj = 0; gj < SIZE; gj++) begin : g_col
      logic [BIT_WIDTH-1:0] a_in;
      logic [BIT_WIDTH-1:0] w_el;
      logic [ACC_WIDTH-1:0] p_in;
      logic [ACC_WIDTH-1:0] a_ext;
      logic [ACC_WIDTH-1:0] w_ext;
      logic [ACC_WIDTH-1:0] prod;
      logic [BIT_WIDTH-1:0] act_reg;
      logic [ACC_WIDTH-1:0] psum_reg;

      if (gj == 0) begin : g_a0
        assign a_in = act_left[gi];
      end else begin : g_an
        assign a_in = act_w[gi][gj-1];
      end

      if (gi == 0) begin : g_p0
        assign p_in = '0;
      end else begin : g_pn
        assign p_in = psum_w[gi-1][gj];
      end

      assign w_el = w_rows[gi][gj*BIT_WIDTH +: BIT_WIDTH];

      // Extending before the multiply keeps the low ACC_WIDTH product bits exact.
      if (SIGNED != 0) begin : g_sx
        assign a_ext = {{EXT_W{a_in[BIT_WIDTH-1]}}, a_in};
        assign w_ext = {{EXT_W{w_el[BIT_WIDTH-1]}}, w_el};
      end else begin : g_zx
        assign a_ext = {{EXT_W{1'b0}}, a_in};
        assign w_ext = {{EXT_W{1'b0}}, w_el};
      end

      assign prod = a_ext * w_ext;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          act_reg  <= '0;
          psum_reg <= '0;
        end else begin
          act_reg  <= a_in;
          psum_reg <= p_in + prod;
        end
      end

      assign act_w[gi][gj]  = act_reg;
      assign psum_w[gi][gj] = psum_reg;
    end
  end

  // Output de-skew: column j is ready SIZE-1-j cycles before the last column.
  for (genvar gi = 0; gi < SIZE; gi++) begin : g_deskew
    localparam int D = SIZE - 1 - gi;
    if (D == 0) begin : g_direct
      assign aligned[gi*ACC_WIDTH +: ACC_WIDTH] = psum_w[SIZE-1][gi];
    end else begin : g_delay
      logic [ACC_WIDTH-1:0] ds_reg [D];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < D; d++) ds_reg[d] <= '0;
        end else begin
          ds_reg[0] <= psum_w[SIZE-1][gi];
          for (int d = 1; d < D; d++) ds_reg[d] <= ds_reg[d-1];
        end
      end
      assign aligned[gi*ACC_WIDTH +: ACC_WIDTH] = ds_reg[D-1];
    end
  end

  // Valid token tracks each accepted vector through the 2*SIZE cycle pipe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vpipe_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_vec_reg   <= '0;
    end else begin
      vpipe_reg     <= {vpipe_reg[LAT-2:0], in_accept};
      out_valid_reg <= vpipe_reg[LAT-1];
      out_vec_reg   <= vpipe_reg[LAT-1] ? aligned : '0;
    end
  end

  assign wt_ready  = wt_ready_reg;
  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_vec   = out_vec_reg;
  assign busy      = (|vpipe_reg) | out_valid_reg;

endmodule

// File: tb/tb_ws_systolic_array.sv
// Directed bench for ws_systolic_array: an unsigned and a signed instance
// share all inputs so each vector is checked against both arithmetic modes.
module tb_ws_systolic_array;

  logic        clk = 1'b0;
  logic        reset;
  logic        wt_valid;
  logic [31:0] wt_row;
  logic        wt_reload;
  logic        in_valid;
  logic [31:0] in_vec;

  logic        wt_ready_u, in_ready_u, out_valid_u, busy_u;
  logic [63:0] out_vec_u;
  logic        wt_ready_s, in_ready_s, out_valid_s, busy_s;
  logic [63:0] out_vec_s;

  int total = 0;
  int bad   = 0;

  int          lat;
  logic [63:0] ru;
  logic [63:0] rs;

  always #5 clk = ~clk;

  ws_systolic_array #(.BIT_WIDTH(8), .ACC_WIDTH(16), .SIZE(4), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset),
    .wt_valid(wt_valid), .wt_row(wt_row), .wt_ready(wt_ready_u), .wt_reload(wt_reload),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready_u),
    .out_valid(out_valid_u), .out_vec(out_vec_u), .busy(busy_u)
  );

  ws_systolic_array #(.BIT_WIDTH(8), .ACC_WIDTH(16), .SIZE(4), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset),
    .wt_valid(wt_valid), .wt_row(wt_row), .wt_ready(wt_ready_s), .wt_reload(wt_reload),
    .in_valid(in_valid), .in_vec(in_vec), .in_ready(in_ready_s),
    .out_valid(out_valid_s), .out_vec(out_vec_s), .busy(busy_s)
  );

  function automatic logic [127:0] diag(input logic [7:0] v);
    logic [127:0] w;
    w = '0;
    for (int r = 0; r < 4; r++) w[r*32 + r*8 +: 8] = v;
    return w;
  endfunction

  function automatic logic [127:0] fill(input logic [7:0] v);
    return {16{v}};
  endfunction

  function automatic logic [31:0] vec4(input logic [7:0] a, input logic [7:0] b,
                                       input logic [7:0] c, input logic [7:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [63:0] res4(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c, input logic [15:0] d);
    return {d, c, b, a};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input logic [127:0] w);
    for (int r = 0; r < 4; r++) begin
      wt_valid = 1'b1;
      wt_row   = w[r*32 +: 32];
      total++;
      if (wt_ready_u !== 1'b1) begin
        $display("FAIL load_wt_ready beat %0d: got %b want 1", r, wt_ready_u);
        bad++;
      end
      tick();
    end
    wt_valid = 1'b0;
    wt_row   = '0;
    total++;
    if (in_ready_u !== 1'b1 || wt_ready_u !== 1'b0) begin
      $display("FAIL load_to_compute: in_ready=%b wt_ready=%b want 1/0", in_ready_u, wt_ready_u);
      bad++;
    end
    $display("weights loaded %h", w);
  endtask

  task automatic do_reload;
    int waited;
    wt_reload = 1'b1;
    tick();
    wt_reload = 1'b0;
    waited = 0;
    while (wt_ready_u !== 1'b1 && waited < 30) begin
      tick();
      waited++;
    end
    total++;
    if (wt_ready_u !== 1'b1) begin
      $display("FAIL reload_timeout: wt_ready=%b want 1 within 30 cycles", wt_ready_u);
      bad++;
    end
  endtask

  // Offers one vector, then waits (bounded) for its result.
  task automatic run_vector(input logic [31:0] v, output int l,
                            output logic [63:0] r_u, output logic [63:0] r_s);
    in_valid = 1'b1;
    in_vec   = v;
    tick();
    in_valid = 1'b0;
    in_vec   = '0;
    l   = -1;
    r_u = '0;
    r_s = '0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (out_valid_u === 1'b1) begin
        l   = c;
        r_u = out_vec_u;
        r_s = out_vec_s;
        break;
      end
    end
    $display("vector %h -> latency %0d result_u %h result_s %h", v, l, r_u, r_s);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    wt_valid = 1'b0; wt_row = '0; wt_reload = 1'b0; in_valid = 1'b0; in_vec = '0;
    #12;
    total++;
    if (wt_ready_u !== 1'b1 || in_ready_u !== 1'b0) begin
      $display("FAIL reset_ready: wt_ready=%b in_ready=%b want 1/0", wt_ready_u, in_ready_u);
      bad++;
    end
    total++;
    if (out_valid_u !== 1'b0 || out_vec_u !== 64'h0 || busy_u !== 1'b0) begin
      $display("FAIL reset_out: out_valid=%b out_vec=%h busy=%b want 0/0/0", out_valid_u, out_vec_u, busy_u);
      bad++;
    end
    total++;
    if (out_valid_s !== 1'b0 || out_vec_s !== 64'h0 || wt_ready_s !== 1'b1) begin
      $display("FAIL reset_signed: out_valid=%b out_vec=%h wt_ready=%b want 0/0/1", out_valid_s, out_vec_s, wt_ready_s);
      bad++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_identity;
    load_weights(diag(8'd1));
    run_vector(vec4(8'd1, 8'd2, 8'd3, 8'd4), lat, ru, rs);
    total++;
    if (lat !== 8) begin
      $display("FAIL identity_latency: got %0d want 8", lat);
      bad++;
    end
    total++;
    if (ru !== res4(16'd1, 16'd2, 16'd3, 16'd4)) begin
      $display("FAIL identity_result: got %h want %h", ru, res4(16'd1, 16'd2, 16'd3, 16'd4));
      bad++;
    end
    tick();
    total++;
    if (out_valid_u !== 1'b0 || out_vec_u !== 64'h0 || busy_u !== 1'b0) begin
      $display("FAIL identity_idle: out_valid=%b out_vec=%h busy=%b want 0/0/0", out_valid_u, out_vec_u, busy_u);
      bad++;
    end
  endtask

  task automatic test_back_to_back;
    int waited;
    do_reload();
    load_weights(fill(8'd1));
    for (int n = 1; n <= 8; n++) begin
      in_valid = 1'b1;
      in_vec   = vec4(8'(n), 8'(n), 8'(n), 8'(n));
      tick();
      if (n == 1) begin
        total++;
        if (busy_u !== 1'b1) begin
          $display("FAIL b2b_busy: got %b want 1", busy_u);
          bad++;
        end
      end
    end
    in_valid = 1'b0;
    in_vec   = '0;
    waited = 0;
    while (out_valid_u !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    for (int n = 1; n <= 8; n++) begin
      total++;
      if (out_valid_u !== 1'b1 || out_vec_u !== res4(16'(4*n), 16'(4*n), 16'(4*n), 16'(4*n))) begin
        $display("FAIL b2b_result %0d: valid=%b got %h want %h", n, out_valid_u, out_vec_u,
                 res4(16'(4*n), 16'(4*n), 16'(4*n), 16'(4*n)));
        bad++;
      end else begin
        $display("b2b result %0d: %h", n, out_vec_u);
      end
      tick();
    end
    total++;
    if (out_valid_u !== 1'b0) begin
      $display("FAIL b2b_end: out_valid=%b want 0", out_valid_u);
      bad++;
    end
  endtask

  task automatic test_bubbles;
    int waited;
    in_valid = 1'b1; in_vec = vec4(8'd1, 8'd2, 8'd3, 8'd4); tick();
    in_valid = 1'b0; in_vec = '0;                          tick();
    in_valid = 1'b1; in_vec = vec4(8'd5, 8'd5, 8'd5, 8'd5); tick();
    in_valid = 1'b0; in_vec = '0;
    waited = 0;
    while (out_valid_u !== 1'b1 && waited < 20) begin
      tick();
      waited++;
    end
    total++;
    if (out_valid_u !== 1'b1 || out_vec_u !== res4(16'd10, 16'd10, 16'd10, 16'd10)) begin
      $display("FAIL bubble_first: valid=%b got %h want %h", out_valid_u, out_vec_u, res4(16'd10, 16'd10, 16'd10, 16'd10));
      bad++;
    end
    tick();
    total++;
    if (out_valid_u !== 1'b0 || out_vec_u !== 64'h0) begin
      $display("FAIL bubble_gap: valid=%b out_vec=%h want 0/0", out_valid_u, out_vec_u);
      bad++;
    end
    tick();
    total++;
    if (out_valid_u !== 1'b1 || out_vec_u !== res4(16'd20, 16'd20, 16'd20, 16'd20)) begin
      $display("FAIL bubble_second: valid=%b got %h want %h", out_valid_u, out_vec_u, res4(16'd20, 16'd20, 16'd20, 16'd20));
      bad++;
    end
    tick();
  endtask

  task automatic test_arith_extremes;
    do_reload();
    load_weights(fill(8'hFF));
    run_vector(vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), lat, ru, rs);
    total++;
    if (lat !== 8 || ru !== {4{16'hF804}}) begin
      $display("FAIL unsigned_wrap: latency=%0d got %h want 8 / %h", lat, ru, {4{16'hF804}});
      bad++;
    end
    total++;
    if (rs !== {4{16'h0004}}) begin
      $display("FAIL signed_neg_sq: got %h want %h", rs, {4{16'h0004}});
      bad++;
    end
    tick();
    do_reload();
    load_weights(fill(8'h02));
    run_vector(vec4(8'hFF, 8'hFF, 8'hFF, 8'hFF), lat, ru, rs);
    total++;
    if (rs !== {4{16'hFFF8}}) begin
      $display("FAIL signed_result: got %h want %h", rs, {4{16'hFFF8}});
      bad++;
    end
    total++;
    if (ru !== {4{16'h07F8}}) begin
      $display("FAIL unsigned_times2: got %h want %h", ru, {4{16'h07F8}});
      bad++;
    end
    tick();
  endtask

  // Weights are all 0x02 here, so vector (n,n,n,n) gives 8n per lane.
  task automatic test_reload_drain;
    int idx;
    in_valid = 1'b1; in_vec = vec4(8'd1, 8'd1, 8'd1, 8'd1); tick();
    in_vec = vec4(8'd2, 8'd2, 8'd2, 8'd2);                  tick();
    in_vec = vec4(8'd3, 8'd3, 8'd3, 8'd3); wt_reload = 1'b1; tick();
    in_valid = 1'b0; in_vec = '0; wt_reload = 1'b0;
    total++;
    if (in_ready_u !== 1'b0 || wt_ready_u !== 1'b0 || busy_u !== 1'b1) begin
      $display("FAIL drain_enter: in_ready=%b wt_ready=%b busy=%b want 0/0/1", in_ready_u, wt_ready_u, busy_u);
      bad++;
    end
    // Weight beats offered while draining must be ignored.
    wt_valid = 1'b1;
    wt_row   = 32'hFFFF_FFFF;
    idx = 0;
    for (int c = 0; c < 30 && idx < 3; c++) begin
      tick();
      if (out_valid_u === 1'b1) begin
        idx++;
        total++;
        if (out_vec_u !== res4(16'(8*idx), 16'(8*idx), 16'(8*idx), 16'(8*idx)) || wt_ready_u !== 1'b0) begin
          $display("FAIL drain_result %0d: got %h wt_ready=%b want %h / 0", idx, out_vec_u, wt_ready_u,
                   res4(16'(8*idx), 16'(8*idx), 16'(8*idx), 16'(8*idx)));
          bad++;
        end else begin
          $display("drain result %0d: %h", idx, out_vec_u);
        end
      end
    end
    wt_valid = 1'b0;
    wt_row   = '0;
    total++;
    if (idx !== 3) begin
      $display("FAIL drain_count: got %0d results want 3", idx);
      bad++;
    end
    tick();
    total++;
    if (wt_ready_u !== 1'b1 || busy_u !== 1'b0 || in_ready_u !== 1'b0) begin
      $display("FAIL drain_to_load: wt_ready=%b busy=%b in_ready=%b want 1/0/0", wt_ready_u, busy_u, in_ready_u);
      bad++;
    end
  endtask

  task automatic test_reset_flight;
    int seen;
    load_weights(diag(8'd1));
    in_valid = 1'b1; in_vec = vec4(8'd1, 8'd2, 8'd3, 8'd4); tick();
    in_valid = 1'b0; in_vec = '0;
    tick();
    tick();
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (wt_ready_u !== 1'b1 || in_ready_u !== 1'b0 || busy_u !== 1'b0) begin
      $display("FAIL midflight_reset: wt_ready=%b in_ready=%b busy=%b want 1/0/0", wt_ready_u, in_ready_u, busy_u);
      bad++;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Load starts immediately: beat 0 must be taken on the first edge.
    load_weights(diag(8'd2));
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid_u !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      $display("FAIL flushed_vector: out_valid high %0d cycles want 0", seen);
      bad++;
    end
    run_vector(vec4(8'd1, 8'd2, 8'd3, 8'd4), lat, ru, rs);
    total++;
    if (lat !== 8 || ru !== res4(16'd2, 16'd4, 16'd6, 16'd8)) begin
      $display("FAIL double_identity: latency=%0d got %h want 8 / %h", lat, ru, res4(16'd2, 16'd4, 16'd6, 16'd8));
      bad++;
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_identity();
    test_back_to_back();
    test_bubbles();
    test_arith_extremes();
    test_reload_drain();
    test_reset_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
